evg_link_tx: RTL
================

EVG_LINK_TX -- requirements
Module: evg_link_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per shared-data frame (1..64).
REQ-002 SHALL have parameter COMMA_PERIOD_LOG2, default 2: the comma slot occurs every 2**COMMA_PERIOD_LOG2 cycles.
REQ-003 SHALL have port tx_clk  in  1  the single clock (one clock; every flop in this block is on tx_clk).
REQ-004 SHALL have port aresetn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tx_ready  in  1  link aligned; while it is low, no events and no frames are sent.
REQ-006 SHALL have ports ev_valid  in  1, ev_code  in  8 and ev_ready  out  1: valid/ready event input.
REQ-007 SHALL have port beacon_req  in  1  single-cycle beacon request.
REQ-008 SHALL have ports sd_valid  in  1, sd_data  in  8, sd_last  in  1, sd_addr  in  16 and sd_ready  out  1: shared-data byte stream; sd_addr is sampled on the first beat of each frame.
REQ-009 SHALL have port tx_data  out  16  GTP data; [7:0] carries events, [15:8] carries shared data.
REQ-010 SHALL have port tx_charisk  out  2  K-flags for the two bytes of tx_data.
REQ-011 SHALL have port frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-012 SHALL register tx_data and tx_charisk.
REQ-013 SHALL run a free-running slot counter; a slot is a comma slot when the counter is 0.
REQ-014 SHALL set the low byte by priority: pending beacon 0x7E (K=0), then comma 0xBC (K=1), then pending event ev_code (K=0), then idle 0x00 (K=0).
REQ-015 SHALL let a beacon displace a comma; an event displaced by a beacon or comma SHALL stay pending.
REQ-016 SHALL drive ev_ready = !ev_pend; an event accepted at edge N SHALL appear on tx_data no earlier than after edge N+1.
REQ-017 SHALL consume ev_code 0x00 without transmitting it.
REQ-018 SHALL merge a beacon_req that arrives while a beacon is already pending into that pending beacon.
REQ-019 SHALL implement the high-byte FSM states FILL, SOF, ADDR_HI, ADDR_LO, DATA, CSUM, EOF and GAP.
REQ-020 In FILL, SHALL hold sd_ready=1 and store bytes in the frame buffer; SHALL leave FILL when sd_last is seen or MAX_LEN bytes are stored.
REQ-021 SHALL continue the bytes that follow a frame cut at MAX_LEN as the next frame, using a new sd_addr sample.
REQ-022 SHALL hold sd_ready=0 in every state except FILL.
REQ-023 SHALL transmit a frame as 0x1C (K28.0, K=1), addr[15:8], addr[7:0], len payload bytes, csum, then 0x3C (K28.1, K=1).
REQ-024 SHALL compute csum as the two's complement of the 8-bit sum of the address bytes and payload bytes, so that the frame body sums to 0 mod 256.
REQ-025 In GAP, SHALL emit one 0x00 (K=0) byte and then return to FILL.
REQ-026 SHALL increment frame_cnt on EOF.
REQ-027 When tx_ready is low, SHALL emit idle on the high byte, keep the buffer, and return any transmit state to SOF; comma slots SHALL continue.
REQ-028 Outside frames, SHALL send the high byte as 0x00 with K=0.

Reset
REQ-029 While aresetn is low: tx_data=0, tx_charisk=0, ev_ready=0, sd_ready=0, frame_cnt=0, slot counter=0, no pending event or beacon, state FILL with the buffer empty.
REQ-030 SHALL discard any frame in progress when reset is asserted; no EOF is sent for it.

Configuration
REQ-031 With EVG_BEACON_EN defined, SHALL provide beacons as in REQ-014 and REQ-018, and SHALL consume ev_code 0x7E without transmitting it.
REQ-032 Without EVG_BEACON_EN, SHALL ignore beacon_req, SHALL include no beacon logic, and SHALL transmit ev_code 0x7E as a normal event.

Structure
REQ-033 SHALL take the K-codes (0xBC, 0x1C, 0x3C), the beacon code 0x7E and the FSM state enum from a shared package evr_pkg.
REQ-034 SHALL implement the frame buffer and its byte count as a sub-module evg_frame_buf.

Verification
REQ-035 Reset released with tx_ready=1 and no traffic -> low byte 0xBC K=1 every 4th cycle, 0x00 otherwise; high byte 0x00.
REQ-036 Frame with addr 0x0102 and bytes 0x10,0x20 (last) -> high byte 1C(K),01,02,10,20,CD,3C(K),00; frame_cnt=1.
REQ-037 ev_code 0x55 accepted at the edge before a comma slot -> 0xBC sent first, then 0x55 in the next slot; ev_ready low until 0x55 is sent.
REQ-038 beacon_req on a comma slot while event 0x21 is pending -> 0x7E, then 0x21, then the comma in its next period; 0x7E never has K=1.
REQ-039 20-byte stream with last on byte 20 (MAX_LEN=16) -> a 16-byte frame, then a 4-byte frame with a new address; frame_cnt advances by 2.
REQ-040 tx_ready dropped during DATA, then raised -> the frame is resent in full from SOF with an identical csum.

Source files
------------

// File: rtl/evr_pkg.sv
// Shared constants and high-byte FSM state type for the event-link transmitter.
package evr_pkg;

    localparam logic [7:0] K28_5       = 8'hBC;
    localparam logic [7:0] K28_0       = 8'h1C;
    localparam logic [7:0] K28_1       = 8'h3C;
    localparam logic [7:0] BEACON_CODE = 8'h7E;
    localparam logic [7:0] IDLE_BYTE   = 8'h00;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_SOF,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_EOF,
        ST_GAP
    } sd_state_e;

    // Two's complement of the running sum, so the frame body sums to zero.
    function automatic logic [7:0] csum8(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/evg_frame_buf.sv
// Shared-data frame buffer: payload bytes, byte count, sampled address and checksum.
module evg_frame_buf
    import evr_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             tx_clk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [15:0]      wr_addr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      addr,
    output logic [7:0]       csum
);

    logic [7:0]       mem_q [2**IDX_W];
    logic [CNT_W-1:0] count_q;
    logic [15:0]      addr_q;
    logic [7:0]       sum_q;

    always_ff @(posedge tx_clk) begin
        if (wr_en) begin
            mem_q[count_q[IDX_W-1:0]] <= wr_data;
        end
    end

    // Address is captured on the first byte, which also seeds the checksum.
    always_ff @(posedge tx_clk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
        end else if (clr) begin
            count_q <= '0;
            sum_q   <= '0;
        end else if (wr_en) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == '0) begin
                addr_q <= wr_addr;
                sum_q  <= wr_addr[15:8] + wr_addr[7:0] + wr_data;
            end else begin
                sum_q  <= sum_q + wr_data;
            end
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign count   = count_q;
    assign addr    = addr_q;
    assign csum    = csum8(sum_q);

endmodule

// File: rtl/evg_link_tx.sv
// Event-link transmitter: events/commas/beacons on the low byte, framed shared data on the high byte.
// Define EVG_BEACON_EN to build the beacon path.
module evg_link_tx
    import evr_pkg::*;
#(
    parameter int MAX_LEN           = 16,
    parameter int COMMA_PERIOD_LOG2 = 2
) (
    input  logic        tx_clk,
    input  logic        aresetn,
    input  logic        tx_ready,
    input  logic        ev_valid,
    input  logic [7:0]  ev_code,
    output logic        ev_ready,
    input  logic        beacon_req,
    input  logic        sd_valid,
    input  logic [7:0]  sd_data,
    input  logic        sd_last,
    input  logic [15:0] sd_addr,
    output logic        sd_ready,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_charisk,
    output logic [15:0] frame_cnt
);

    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int SLOT_W = (COMMA_PERIOD_LOG2 > 0) ? COMMA_PERIOD_LOG2 : 1;

    logic              run_q;
    logic [SLOT_W-1:0] slot_q;
    logic              comma_slot;
    logic              ev_pend_q, ev_pend_d;
    logic [7:0]        ev_code_q, ev_code_d;
    logic              ev_drop;
    logic [7:0]        lo_d;
    logic              lo_k;
    sd_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        hi_d;
    logic              hi_k;
    logic              buf_clr;
    logic              cnt_inc;
    logic              sd_take;
    logic [7:0]        buf_rd;
    logic [CNT_W-1:0]  buf_count;
    logic [15:0]       buf_addr;
    logic [7:0]        buf_csum;
    logic [15:0]       tx_data_q;
    logic [1:0]        tx_charisk_q;
    logic [15:0]       frame_cnt_q;

    assign comma_slot = (COMMA_PERIOD_LOG2 == 0) || (slot_q == '0);
    assign ev_ready   = run_q && !ev_pend_q;
    assign sd_ready   = run_q && (state_q == ST_FILL);
    assign sd_take    = sd_valid && sd_ready;

`ifdef EVG_BEACON_EN
    logic bcn_pend_q, bcn_pend_d;

    assign ev_drop = (ev_code == IDLE_BYTE) || (ev_code == BEACON_CODE);

    always_ff @(posedge tx_clk or negedge aresetn) begin
        if (!aresetn) begin
            bcn_pend_q <= 1'b0;
        end else begin
            bcn_pend_q <= bcn_pend_d;
        end
    end
`else
    logic unused_beacon_req;

    assign ev_drop           = (ev_code == IDLE_BYTE);
    assign unused_beacon_req = beacon_req;
`endif

    // Low byte: beacon, then comma, then event, then idle.
    always_comb begin
        lo_d      = IDLE_BYTE;
        lo_k      = 1'b0;
        ev_pend_d = ev_pend_q;
        ev_code_d = ev_code_q;
`ifdef EVG_BEACON_EN
        // A request landing while one is pending (or being sent) merges into it.
        bcn_pend_d = bcn_pend_q | (beacon_req & run_q);
        if (bcn_pend_q && tx_ready) begin
            lo_d       = BEACON_CODE;
            bcn_pend_d = 1'b0;
        end else if (comma_slot) begin
            lo_d = K28_5;
            lo_k = 1'b1;
        end else if (ev_pend_q && tx_ready) begin
            lo_d      = ev_code_q;
            ev_pend_d = 1'b0;
        end
`else
        if (comma_slot) begin
            lo_d = K28_5;
            lo_k = 1'b1;
        end else if (ev_pend_q && tx_ready) begin
            lo_d      = ev_code_q;
            ev_pend_d = 1'b0;
        end
`endif
        if (ev_valid && ev_ready && !ev_drop) begin
            ev_pend_d = 1'b1;
            ev_code_d = ev_code;
        end
    end

    // High-byte frame FSM; losing tx_ready mid-frame restarts it from SOF.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hi_d    = IDLE_BYTE;
        hi_k    = 1'b0;
        buf_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state_q != ST_FILL && state_q != ST_GAP && !tx_ready) begin
            state_d = ST_SOF;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (sd_take && (sd_last || buf_count == CNT_W'(MAX_LEN - 1))) begin
                        state_d = ST_SOF;
                    end
                end
                ST_SOF: begin
                    hi_d    = K28_0;
                    hi_k    = 1'b1;
                    state_d = ST_ADDR_HI;
                end
                ST_ADDR_HI: begin
                    hi_d    = buf_addr[15:8];
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    hi_d    = buf_addr[7:0];
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    hi_d  = buf_rd;
                    idx_d = idx_q + IDX_W'(1);
                    if (CNT_W'(idx_q) + CNT_W'(1) == buf_count) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    hi_d    = buf_csum;
                    state_d = ST_EOF;
                end
                ST_EOF: begin
                    hi_d    = K28_1;
                    hi_k    = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    buf_clr = 1'b1;
                    state_d = ST_FILL;
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge aresetn) begin
        if (!aresetn) begin
            run_q        <= 1'b0;
            slot_q       <= '0;
            ev_pend_q    <= 1'b0;
            ev_code_q    <= '0;
            state_q      <= ST_FILL;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_charisk_q <= '0;
            frame_cnt_q  <= '0;
        end else begin
            run_q        <= 1'b1;
            slot_q       <= slot_q + SLOT_W'(1);
            ev_pend_q    <= ev_pend_d;
            ev_code_q    <= ev_code_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_data_q    <= {hi_d, lo_d};
            tx_charisk_q <= {hi_k, lo_k};
            if (cnt_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    evg_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_frame_buf (
        .tx_clk  (tx_clk),
        .aresetn (aresetn),
        .clr     (buf_clr),
        .wr_en   (sd_take),
        .wr_data (sd_data),
        .wr_addr (sd_addr),
        .rd_idx  (idx_q),
        .rd_data (buf_rd),
        .count   (buf_count),
        .addr    (buf_addr),
        .csum    (buf_csum)
    );

    assign tx_data    = tx_data_q;
    assign tx_charisk = tx_charisk_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
